// File: rtl/id_ex_issue_if.sv
// id_ex_issue_if: ID-side inputs, forwarding sources and EX-side outputs of the ID/EX issue stage.
// HAZARD_STATS_EN adds the stall_count/flush_count outputs.
interface id_ex_issue_if #(parameter int DATA_W = 32, parameter int REG_AW = 5);
    logic              id_valid;
    logic [DATA_W-1:0] id_read_data1, id_read_data2, id_inst_extended, id_shamnt;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic              id_AluSrc1, id_AluSrc;
    logic [3:0]        id_AluOperation;
    logic              id_reg_write, id_mem_read, id_mem_write;
    logic              hold, flush;
    logic              mem_reg_write, wb_reg_write;
    logic [REG_AW-1:0] mem_rd, wb_rd;
    logic [DATA_W-1:0] mem_alu_result, wb_data;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_read_data1_reg, ex_read_data2_reg, ex_inst_extended, ex_shamnt;
    logic              ex_AluSrc1, ex_AluSrc;
    logic [3:0]        ex_AluOperation;
    logic              ex_reg_write, ex_mem_read, ex_mem_write;
    logic [REG_AW-1:0] ex_rd;
    logic              load_use_stall;
`ifdef HAZARD_STATS_EN
    logic [31:0]       stall_count, flush_count;
`endif
    modport master (
`ifdef HAZARD_STATS_EN
        input  stall_count, flush_count,
`endif
        output id_valid, id_read_data1, id_read_data2, id_inst_extended, id_shamnt,
               id_rs, id_rt, id_rd, id_AluSrc1, id_AluSrc, id_AluOperation,
               id_reg_write, id_mem_read, id_mem_write, hold, flush,
               mem_reg_write, mem_rd, mem_alu_result, wb_reg_write, wb_rd, wb_data,
        input  ex_valid, ex_read_data1_reg, ex_read_data2_reg, ex_inst_extended, ex_shamnt,
               ex_AluSrc1, ex_AluSrc, ex_AluOperation, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_rd, load_use_stall
    );
    modport slave (
`ifdef HAZARD_STATS_EN
        output stall_count, flush_count,
`endif
        input  id_valid, id_read_data1, id_read_data2, id_inst_extended, id_shamnt,
               id_rs, id_rt, id_rd, id_AluSrc1, id_AluSrc, id_AluOperation,
               id_reg_write, id_mem_read, id_mem_write, hold, flush,
               mem_reg_write, mem_rd, mem_alu_result, wb_reg_write, wb_rd, wb_data,
        output ex_valid, ex_read_data1_reg, ex_read_data2_reg, ex_inst_extended, ex_shamnt,
               ex_AluSrc1, ex_AluSrc, ex_AluOperation, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_rd, load_use_stall
    );
endinterface

// File: rtl/id_ex_issue.sv
// id_ex_issue: ID/EX pipeline register with MEM/WB operand forwarding and load-use stall.
// HAZARD_STATS_EN adds saturating stall_count/flush_count counters.
module id_ex_issue #(parameter int DATA_W = 32, parameter int REG_AW = 5) (
    input logic          clk,
    input logic          rst,
    id_ex_issue_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs, rt, rd;
        logic [DATA_W-1:0] rd1, rd2, imm, sh;
        logic              alu_src1, alu_src;
        logic [3:0]        alu_op;
        logic              reg_write, mem_read, mem_write;
    } stage_t;
    stage_t q, nxt;
    logic stall;
    assign stall = bus.id_valid & q.valid & q.mem_read & (q.rd != '0) & ((q.rd == bus.id_rs) | (q.rd == bus.id_rt));
    always_comb begin
        nxt = '{valid: bus.id_valid, rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd,
                rd1: bus.id_read_data1, rd2: bus.id_read_data2, imm: bus.id_inst_extended, sh: bus.id_shamnt,
                alu_src1: bus.id_AluSrc1, alu_src: bus.id_AluSrc, alu_op: bus.id_AluOperation,
                reg_write: bus.id_reg_write & bus.id_valid, mem_read: bus.id_mem_read & bus.id_valid,
                mem_write: bus.id_mem_write & bus.id_valid};
        nxt = (bus.flush | stall) ? '0 : nxt;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (!bus.hold) q <= nxt;
    // MEM is the younger producer, so it takes precedence over WB; $0 never forwards.
    assign bus.ex_read_data1_reg = (bus.mem_reg_write && bus.mem_rd != '0 && bus.mem_rd == q.rs) ? bus.mem_alu_result :
                                   (bus.wb_reg_write && bus.wb_rd != '0 && bus.wb_rd == q.rs) ? bus.wb_data : q.rd1;
    assign bus.ex_read_data2_reg = (bus.mem_reg_write && bus.mem_rd != '0 && bus.mem_rd == q.rt) ? bus.mem_alu_result :
                                   (bus.wb_reg_write && bus.wb_rd != '0 && bus.wb_rd == q.rt) ? bus.wb_data : q.rd2;
    assign bus.ex_valid         = q.valid;
    assign bus.ex_inst_extended = q.imm;
    assign bus.ex_shamnt        = q.sh;
    assign bus.ex_AluSrc1       = q.alu_src1;
    assign bus.ex_AluSrc        = q.alu_src;
    assign bus.ex_AluOperation  = q.alu_op;
    assign bus.ex_reg_write     = q.reg_write;
    assign bus.ex_mem_read      = q.mem_read;
    assign bus.ex_mem_write     = q.mem_write;
    assign bus.ex_rd            = q.rd;
    assign bus.load_use_stall   = stall;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, flush_cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!bus.hold) begin
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (bus.flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    assign bus.stall_count = stall_cnt;
    assign bus.flush_count = flush_cnt;
`endif
endmodule

// File: tb/tb_id_ex_issue.sv
// tb_id_ex_issue: random stimulus against an instruction-slot model, forwarding vector table,
// and directed load-use / flush / hold / async-reset sequences.
module tb_id_ex_issue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    id_ex_issue_if bus();
    id_ex_issue dut(.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic v;
        logic [4:0] rs, rt, rd;
        logic [31:0] d1, d2, imm, sh;
        logic s1, s0;
        logic [3:0] op;
        logic rw, mr, mw;
    } slot_t;
    typedef struct {
        logic [4:0] rs, rt;
        logic [31:0] rf1, rf2;
        logic mrw;
        logic [4:0] mrd;
        logic [31:0] mval;
        logic wrw;
        logic [4:0] wrd;
        logic [31:0] wval, e1, e2;
    } fwd_vec_t;

    int n_pass = 0;
    int n_total = 0;
    slot_t m = '0;
`ifdef HAZARD_STATS_EN
    logic [31:0] sc = '0;
    logic [31:0] fc = '0;
    logic [31:0] base;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic exp_stall();
        return bus.id_valid && m.v && m.mr && m.rd != 5'd0 && (m.rd == bus.id_rs || m.rd == bus.id_rt);
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf);
        if (bus.mem_reg_write && bus.mem_rd != 5'd0 && bus.mem_rd == src) return bus.mem_alu_result;
        if (bus.wb_reg_write && bus.wb_rd != 5'd0 && bus.wb_rd == src) return bus.wb_data;
        return rf;
    endfunction

    // Model: the EX slot holds one whole instruction; it is frozen, replaced by a bubble, or replaced by ID.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m <= '0;
`ifdef HAZARD_STATS_EN
            sc <= '0;
            fc <= '0;
`endif
        end else if (!bus.hold) begin
            if (bus.flush || exp_stall()) m <= '0;
            else m <= '{bus.id_valid, bus.id_rs, bus.id_rt, bus.id_rd, bus.id_read_data1, bus.id_read_data2,
                        bus.id_inst_extended, bus.id_shamnt, bus.id_AluSrc1, bus.id_AluSrc, bus.id_AluOperation,
                        bus.id_valid & bus.id_reg_write, bus.id_valid & bus.id_mem_read, bus.id_valid & bus.id_mem_write};
`ifdef HAZARD_STATS_EN
            if (exp_stall() && sc != 32'hFFFF_FFFF) sc <= sc + 1;
            if (bus.flush && fc != 32'hFFFF_FFFF) fc <= fc + 1;
`endif
        end
    end

    task automatic clear_in();
        {bus.id_valid, bus.id_read_data1, bus.id_read_data2, bus.id_inst_extended, bus.id_shamnt} = '0;
        {bus.id_rs, bus.id_rt, bus.id_rd, bus.id_AluSrc1, bus.id_AluSrc, bus.id_AluOperation} = '0;
        {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.hold, bus.flush} = '0;
        {bus.mem_reg_write, bus.mem_rd, bus.mem_alu_result, bus.wb_reg_write, bus.wb_rd, bus.wb_data} = '0;
    endtask

    task automatic rand_in();
        bus.id_valid = ($urandom_range(0, 7) != 0);
        bus.id_read_data1 = $urandom;
        bus.id_read_data2 = $urandom;
        bus.id_inst_extended = $urandom;
        bus.id_shamnt = $urandom_range(0, 31);
        bus.id_rs = 5'($urandom_range(0, 7));
        bus.id_rt = 5'($urandom_range(0, 7));
        bus.id_rd = 5'($urandom_range(0, 7));
        bus.id_AluSrc1 = 1'($urandom);
        bus.id_AluSrc = 1'($urandom);
        bus.id_AluOperation = 4'($urandom);
        bus.id_reg_write = 1'($urandom);
        bus.id_mem_read = ($urandom_range(0, 2) == 0);
        bus.id_mem_write = ($urandom_range(0, 3) == 0);
        bus.hold = ($urandom_range(0, 7) == 0);
        bus.flush = ($urandom_range(0, 7) == 0);
        bus.mem_reg_write = 1'($urandom);
        bus.mem_rd = 5'($urandom_range(0, 7));
        bus.mem_alu_result = $urandom;
        bus.wb_reg_write = 1'($urandom);
        bus.wb_rd = 5'($urandom_range(0, 7));
        bus.wb_data = $urandom;
    endtask

    task automatic check_all();
        chk("ex_valid", 32'(bus.ex_valid), 32'(m.v));
        chk("fwd_op1", bus.ex_read_data1_reg, fwd(m.rs, m.d1));
        chk("fwd_op2", bus.ex_read_data2_reg, fwd(m.rt, m.d2));
        chk("ex_imm", bus.ex_inst_extended, m.imm);
        chk("ex_shamnt", bus.ex_shamnt, m.sh);
        chk("ex_alusrc1", 32'(bus.ex_AluSrc1), 32'(m.s1));
        chk("ex_alusrc", 32'(bus.ex_AluSrc), 32'(m.s0));
        chk("ex_aluop", 32'(bus.ex_AluOperation), 32'(m.op));
        chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(m.rw));
        chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(m.mr));
        chk("ex_mem_write", 32'(bus.ex_mem_write), 32'(m.mw));
        chk("ex_rd", 32'(bus.ex_rd), 32'(m.rd));
        chk("load_use_stall", 32'(bus.load_use_stall), 32'(exp_stall()));
`ifdef HAZARD_STATS_EN
        chk("stall_count", bus.stall_count, sc);
        chk("flush_count", bus.flush_count, fc);
`endif
    endtask

    fwd_vec_t tbl[6];

    initial begin
        tbl[0] = '{5'd3, 5'd4, 32'h11, 32'h22, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 32'hDEADBEEF, 32'h22};
        tbl[1] = '{5'd5, 5'd6, 32'h1, 32'h2, 1'b1, 5'd5, 32'hA, 1'b1, 5'd5, 32'hB, 32'hA, 32'h2};
        tbl[2] = '{5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 32'hA, 1'b1, 5'd0, 32'hB, 32'h0, 32'h0};
        tbl[3] = '{5'd7, 5'd9, 32'h3, 32'h4, 1'b0, 5'd7, 32'hA, 1'b1, 5'd9, 32'hB, 32'h3, 32'hB};
        tbl[4] = '{5'd9, 5'd9, 32'h5, 32'h5, 1'b1, 5'd9, 32'hC, 1'b1, 5'd9, 32'hD, 32'hC, 32'hC};
        tbl[5] = '{5'd2, 5'd8, 32'h6, 32'h7, 1'b1, 5'd8, 32'hE, 1'b1, 5'd2, 32'hF, 32'hF, 32'hE};
        clear_in();
        @(negedge clk);
        #1;
        chk("reset_valid", 32'(bus.ex_valid), 32'd0);
        chk("reset_reg_write", 32'(bus.ex_reg_write), 32'd0);
        chk("reset_stall", 32'(bus.load_use_stall), 32'd0);
        rst = 1'b0;
        repeat (400) begin
            @(negedge clk);
            rand_in();
            #1 check_all();
        end
        foreach (tbl[i]) begin
            @(negedge clk);
            clear_in();
            bus.id_valid = 1'b1;
            bus.id_rs = tbl[i].rs;
            bus.id_rt = tbl[i].rt;
            bus.id_read_data1 = tbl[i].rf1;
            bus.id_read_data2 = tbl[i].rf2;
            @(negedge clk);
            bus.hold = 1'b1;
            {bus.mem_reg_write, bus.mem_rd, bus.mem_alu_result} = {tbl[i].mrw, tbl[i].mrd, tbl[i].mval};
            {bus.wb_reg_write, bus.wb_rd, bus.wb_data} = {tbl[i].wrw, tbl[i].wrd, tbl[i].wval};
            #1;
            chk($sformatf("tbl%0d_op1", i), bus.ex_read_data1_reg, tbl[i].e1);
            chk($sformatf("tbl%0d_op2", i), bus.ex_read_data2_reg, tbl[i].e2);
        end
        // Load-use: lw r8 in EX, add r10 = r8 + r9 in ID.
        @(negedge clk);
        clear_in();
        {bus.id_valid, bus.id_mem_read, bus.id_reg_write, bus.id_rd, bus.id_rs, bus.id_rt} = {3'b111, 5'd8, 5'd1, 5'd2};
        @(negedge clk);
        clear_in();
        {bus.id_valid, bus.id_reg_write, bus.id_rs, bus.id_rt, bus.id_rd, bus.id_AluOperation} = {2'b11, 5'd8, 5'd9, 5'd10, 4'h2};
        #1;
        chk("lu_stall", 32'(bus.load_use_stall), 32'd1);
        chk("lu_lw_rd", 32'(bus.ex_rd), 32'd8);
        @(negedge clk);
        #1;
        chk("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
        chk("lu_bubble_rd", 32'(bus.ex_rd), 32'd0);
        chk("lu_bubble_stall", 32'(bus.load_use_stall), 32'd0);
        @(negedge clk);
        #1;
        chk("lu_add_valid", 32'(bus.ex_valid), 32'd1);
        chk("lu_add_rd", 32'(bus.ex_rd), 32'd10);
        chk("lu_add_reg_write", 32'(bus.ex_reg_write), 32'd1);
        chk("lu_add_stall", 32'(bus.load_use_stall), 32'd0);
        // Hold keeps the lw in EX and the stall asserted.
        clear_in();
        {bus.id_valid, bus.id_mem_read, bus.id_rd} = {2'b11, 5'd8};
        @(negedge clk);
        clear_in();
        {bus.id_valid, bus.id_rs, bus.hold} = {1'b1, 5'd8, 1'b1};
        #1 chk("hold_stall_a", 32'(bus.load_use_stall), 32'd1);
        @(negedge clk);
        #1;
        chk("hold_stall_b", 32'(bus.load_use_stall), 32'd1);
        chk("hold_valid", 32'(bus.ex_valid), 32'd1);
        chk("hold_rd", 32'(bus.ex_rd), 32'd8);
        check_all();
        // Flush with hold keeps contents; flush alone loads a bubble.
        clear_in();
        {bus.id_valid, bus.id_mem_write, bus.id_rd} = {2'b11, 5'd12};
        @(negedge clk);
        #1 chk("fl_loaded_mw", 32'(bus.ex_mem_write), 32'd1);
        {bus.flush, bus.hold} = 2'b11;
`ifdef HAZARD_STATS_EN
        base = fc;
`endif
        @(negedge clk);
        #1;
        chk("flhold_valid", 32'(bus.ex_valid), 32'd1);
        chk("flhold_mw", 32'(bus.ex_mem_write), 32'd1);
        chk("flhold_rd", 32'(bus.ex_rd), 32'd12);
`ifdef HAZARD_STATS_EN
        chk("flhold_count", bus.flush_count, base);
`endif
        bus.hold = 1'b0;
        @(negedge clk);
        #1;
        chk("flush_valid", 32'(bus.ex_valid), 32'd0);
        chk("flush_mw", 32'(bus.ex_mem_write), 32'd0);
`ifdef HAZARD_STATS_EN
        chk("flush_count_inc", bus.flush_count, base + 1);
`endif
        // Asynchronous reset between clock edges.
        clear_in();
        {bus.id_valid, bus.id_mem_read, bus.id_reg_write, bus.id_AluOperation, bus.id_rd} = {3'b111, 4'h5, 5'd8};
        @(negedge clk);
        clear_in();
        {bus.id_valid, bus.id_rs} = {1'b1, 5'd8};
        #1;
        chk("pre_rst_stall", 32'(bus.load_use_stall), 32'd1);
        chk("pre_rst_op", 32'(bus.ex_AluOperation), 32'h5);
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_reg_write", 32'(bus.ex_reg_write), 32'd0);
        chk("rst_aluop", 32'(bus.ex_AluOperation), 32'd0);
        chk("rst_stall", 32'(bus.load_use_stall), 32'd0);
        #1 rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            rand_in();
            #1 check_all();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/id_ex_issue.md
Name: id_ex_issue

Overview:
- ID/EX pipeline register plus operand-forwarding and load-use hazard unit of the 5-stage MIPS pipeline.
- Captures decoded operands and ALU control from the ID stage every cycle.
- Drives the EX stage's operand/control inputs (read_data1_reg, read_data2_reg, inst_extended, shamnt, AluSrc1, AluSrc, AluOperation), with forwarded values from the MEM and WB stages substituted where needed.
- Generates the load-use stall that freezes PC and IF/ID.

Parameters:
- DATA_W, 32, datapath width of operands and forwarded results.
- REG_AW, 5, register-file index width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_read_data1, id_read_data2  in  DATA_W  register-file read values
- id_inst_extended, id_shamnt  in  DATA_W  sign-extended immediate, zero-extended shift amount
- id_rs, id_rt, id_rd  in  REG_AW  source indices and final destination index (0 = no write)
- id_AluSrc1, id_AluSrc  in  1  ALU operand selects
- id_AluOperation  in  4  ALU operation
- id_reg_write, id_mem_read, id_mem_write  in  1  downstream control
- hold  in  1  downstream back-pressure; freeze ID/EX contents
- flush  in  1  squash ID instruction (taken branch/jump)
- mem_reg_write  in  1  EX/MEM instruction writes a register
- mem_rd  in  REG_AW  EX/MEM destination index
- mem_alu_result  in  DATA_W  EX/MEM result
- wb_reg_write  in  1  MEM/WB instruction writes a register
- wb_rd  in  REG_AW  MEM/WB destination index
- wb_data  in  DATA_W  MEM/WB writeback value
- ex_valid  out  1  EX holds a real instruction
- ex_read_data1_reg, ex_read_data2_reg  out  DATA_W  forwarded operands to EX
- ex_inst_extended, ex_shamnt  out  DATA_W  registered immediate and shift amount
- ex_AluSrc1, ex_AluSrc  out  1  registered operand selects
- ex_AluOperation  out  4  registered ALU operation
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control, gated by ex_valid
- ex_rd  out  REG_AW  registered destination
- load_use_stall  out  1  freeze PC and IF/ID this cycle

Behaviour:
- Reset (async, immediate): all registered fields 0, ex_valid=0, every control output 0; combinational outputs therefore 0.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- load_use_stall (combinational) = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs | ex_rd==id_rt).
  - The comparison uses id_rt even for I-type instructions; a conservative false stall is accepted.
- Register update priority at each clock edge, first matching rule wins:
  1. hold=1: keep all contents. hold wins over flush and stall; the stall output stays asserted while the condition holds.
  2. flush=1: load a bubble. A bubble is ex_valid=0, all control 0, ex_rd=0, data fields don't-care and set to 0.
  3. load_use_stall=1: load a bubble. ID must re-present the same instruction next cycle.
  4. Otherwise: load all id_* fields, with ex_valid=id_valid.
- Registered control outputs are gated: written as 0 whenever the loaded id_valid=0.
- Forwarding is combinational on the registered rs/rt, evaluated separately for operand 1 (rs) and operand 2 (rt):
  - MEM wins if mem_reg_write & mem_rd!=0 & mem_rd==src.
  - Else WB wins if wb_reg_write & wb_rd!=0 & wb_rd==src.
  - Else use the registered register-file value.
  - The same-cycle WB write is also covered by this path; the register file need not write-before-read.
- Register 0 is never forwarded: its value is always the registered value, which the register file supplies as 0.
- ex_inst_extended, ex_shamnt, ex_AluSrc1, ex_AluSrc and ex_AluOperation pass through unmodified; operand selection stays in EX.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds outputs stall_count (32) and flush_count (32), both reset to 0.
  - stall_count increments each cycle with load_use_stall=1 and hold=0.
  - flush_count increments each cycle with flush=1 and hold=0.
  - Both saturate at 0xFFFFFFFF.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset mid-stream: rst=1 asynchronously while ex_valid=1 -> ex_valid, ex_reg_write, ex_AluOperation = 0 before the next edge; load_use_stall=0.
- EX/MEM forward: EX holds rs=3, rt=4 (regfile 0x11, 0x22); mem_reg_write=1, mem_rd=3, mem_alu_result=0xDEADBEEF -> ex_read_data1_reg=0xDEADBEEF, ex_read_data2_reg=0x22.
- Priority and $0: mem_rd=wb_rd=5, mem value 0xA, wb value 0xB, rs=5 -> 0xA. With mem_rd=wb_rd=0 and rs=0 -> registered value 0.
- Load-use: EX has lw, ex_rd=8; ID presents add, rs=8 -> load_use_stall=1 for one cycle, then a bubble (ex_valid=0); add enters EX the following cycle with load_use_stall=0.
- Flush vs hold:
  - flush=1 -> next ex_valid=0, ex_mem_write=0.
  - flush=1 with hold=1 -> contents unchanged.
  - With HAZARD_STATS_EN, flush_count is unchanged in the hold case and +1 in the first case.
